// File: rtl/puzzle_round_ctrl.sv
// rtl/puzzle_round_ctrl.sv - round sequencer for the wake-up puzzle
//
// Purpose: an alarm trigger starts a round. The sequencer arms the three
// equation stages in turn and runs the shared seconds timer that the stages
// capture as their target. It re-arms a stage on timeout or user retry,
// counts timeouts as a penalty, and reports completion to display/buzzer.
//
// Ports:
//   Clock         in   system clock
//   Reset         in   synchronous, active-high
//   AlarmTrigger  in   level; rising edge starts a round
//   Retry         in   level (debounced); rising edge re-arms current stage
//   EqCorrect     in   [2:0] correct flags of equation stages 0..2
//   StartEq       out  [2:0] one-cycle start/release pulse per stage
//   OngoingTimer  out  [6:0] seconds counter, wraps after TIMER_MAX
//   Stage         out  [1:0] active stage index
//   AlarmOn       out  high while a round is in progress
//   Solved        out  high once all three stages are solved
//   Penalty       out  [3:0] timeouts this round, saturating at 15
module puzzle_round_ctrl #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int TIMER_MAX   = 99,
    parameter int TIMEOUT_SEC = 60
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       AlarmTrigger,
    input  logic       Retry,
    input  logic [2:0] EqCorrect,
    output logic [2:0] StartEq,
    output logic [6:0] OngoingTimer,
    output logic [1:0] Stage,
    output logic       AlarmOn,
    output logic       Solved,
    output logic [3:0] Penalty
);

    localparam int              CW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   TICK_LAST   = CW'(TICK_DIV - 1);
    localparam logic [6:0]      TIMER_LAST  = 7'(TIMER_MAX);
    localparam logic [6:0]      TIMEOUT_VAL = 7'(TIMEOUT_SEC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   tick_cnt;
    logic [6:0]      timeout_cnt;

    // Two-stage edge detectors: *_s is the sampled input, *_p the sample
    // before it. Both reset high so a level held through reset is not an edge.
    logic       alarm_s, alarm_p;
    logic       retry_s, retry_p;
    logic [2:0] eq_s, eq_p;

    logic       alarm_rise;
    logic       retry_rise;
    logic [2:0] eq_rise;
    logic       tick;
    logic       timeout;

    assign alarm_rise = alarm_s & ~alarm_p;
    assign retry_rise = retry_s & ~retry_p;
    assign eq_rise    = eq_s & ~eq_p;
    assign tick       = AlarmOn && (tick_cnt == TICK_LAST);
    assign timeout    = (timeout_cnt == TIMEOUT_VAL);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= S_IDLE;
            StartEq      <= '0;
            OngoingTimer <= '0;
            Stage        <= '0;
            AlarmOn      <= 1'b0;
            Solved       <= 1'b0;
            Penalty      <= '0;
            tick_cnt     <= '0;
            timeout_cnt  <= '0;
            alarm_s      <= 1'b1;
            alarm_p      <= 1'b1;
            retry_s      <= 1'b1;
            retry_p      <= 1'b1;
            eq_s         <= 3'b111;
            eq_p         <= 3'b111;
        end else begin
            // Edge detectors run in every state so stale flags never look new.
            alarm_s <= AlarmTrigger;
            alarm_p <= alarm_s;
            retry_s <= Retry;
            retry_p <= retry_s;
            eq_s    <= EqCorrect;
            eq_p    <= eq_s;

            StartEq <= '0;

            if (state == S_IDLE) begin
                tick_cnt <= '0;
            end else if (AlarmOn) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            end

            if (tick) begin
                OngoingTimer <= (OngoingTimer == TIMER_LAST) ? '0 : OngoingTimer + 1'b1;
            end

            // Counter action follows the state being left, so ARM's clear
            // beats a coincident tick.
            if (state == S_ARM) begin
                timeout_cnt <= '0;
            end else if (state == S_WAIT && tick) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end

            // Outputs are loaded together with the next state so they are
            // registered yet behave as Moore outputs of that state.
            case (state)
                S_IDLE: begin
                    if (alarm_rise) begin
                        Stage   <= 2'd0;
                        Penalty <= 4'd0;
                        StartEq <= 3'b001;
                        AlarmOn <= 1'b1;
                        state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eq_rise[Stage]) begin
                        StartEq <= 3'b001 << Stage;
                        state   <= S_RELEASE;
                    end else if (timeout) begin
                        StartEq <= 3'b001 << Stage;
                        if (Penalty != 4'd15) begin
                            Penalty <= Penalty + 4'd1;
                        end
                        state <= S_ARM;
                    end else if (retry_rise) begin
                        StartEq <= 3'b001 << Stage;
                        state   <= S_ARM;
                    end
                end
                S_RELEASE: begin
                    if (Stage == 2'd2) begin
                        AlarmOn <= 1'b0;
                        Solved  <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        Stage   <= Stage + 2'd1;
                        StartEq <= 3'b001 << (Stage + 2'd1);
                        state   <= S_ARM;
                    end
                end
                S_DONE: begin
                    if (!AlarmTrigger) begin
                        Solved <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puzzle_round_ctrl.sv
// tb/tb_puzzle_round_ctrl.sv - randomized bench for puzzle_round_ctrl against a phase-level model
module tb_puzzle_round_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int TIMER_MAX   = 5;
    localparam int TIMEOUT_SEC = 3;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_WAIT = 2;
    localparam int P_REL  = 3;
    localparam int P_DONE = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       AlarmTrigger;
    logic       Retry;
    logic [2:0] EqCorrect;
    logic [2:0] StartEq;
    logic [6:0] OngoingTimer;
    logic [1:0] Stage;
    logic       AlarmOn;
    logic       Solved;
    logic [3:0] Penalty;

    puzzle_round_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .TIMER_MAX   (TIMER_MAX),
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .AlarmTrigger (AlarmTrigger),
        .Retry        (Retry),
        .EqCorrect    (EqCorrect),
        .StartEq      (StartEq),
        .OngoingTimer (OngoingTimer),
        .Stage        (Stage),
        .AlarmOn      (AlarmOn),
        .Solved       (Solved),
        .Penalty      (Penalty)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: round phase, stage, elapsed alarm-on cycles since
    // the last idle, total seconds, ticks seen in the current wait.
    int       m_phase, m_stage, m_pen, m_timer, m_sub, m_wticks;
    bit [4:0] m_d1, m_d2;   // {alarm, retry, eq[2:0]} sampled one / two edges ago

    function automatic bit model_on();
        return (m_phase == P_ARM) || (m_phase == P_WAIT) || (m_phase == P_REL);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_stage = 0; m_pen = 0; m_timer = 0; m_sub = 0; m_wticks = 0;
        m_d1 = '1; m_d2 = '1;
    endtask

    task automatic model_edge();
        bit [4:0] rise;
        bit       on, tick, tmo;
        if (Reset) begin
            model_reset();
            return;
        end
        rise = m_d1 & ~m_d2;
        on   = model_on();
        tick = on && ((m_sub % TICK_DIV) == TICK_DIV - 1);
        tmo  = (m_wticks == TIMEOUT_SEC);
        if (m_phase == P_IDLE) m_sub = 0;
        else if (on) m_sub++;
        if (tick) m_timer = (m_timer + 1) % (TIMER_MAX + 1);
        if (m_phase == P_ARM) m_wticks = 0;
        else if (m_phase == P_WAIT && tick) m_wticks++;
        case (m_phase)
            P_IDLE: if (rise[4]) begin m_stage = 0; m_pen = 0; m_phase = P_ARM; end
            P_ARM:  m_phase = P_WAIT;
            P_WAIT: begin
                if (rise[m_stage]) m_phase = P_REL;
                else if (tmo) begin
                    m_phase = P_ARM;
                    if (m_pen < 15) m_pen++;
                end else if (rise[3]) m_phase = P_ARM;
            end
            P_REL: begin
                if (m_stage == 2) m_phase = P_DONE;
                else begin m_stage++; m_phase = P_ARM; end
            end
            default: if (!AlarmTrigger) m_phase = P_IDLE;
        endcase
        m_d2 = m_d1;
        m_d1 = {AlarmTrigger, Retry, EqCorrect};
    endtask

    task automatic compare_all();
        int exp_start;
        exp_start = (m_phase == P_ARM || m_phase == P_REL) ? (1 << m_stage) : 0;
        check("start_eq", StartEq, exp_start);
        check("timer", OngoingTimer, m_timer);
        check("stage", Stage, m_stage);
        check("alarm_on", AlarmOn, model_on());
        check("solved", Solved, m_phase == P_DONE);
        check("penalty", Penalty, m_pen);
        check("onehot", $countones(StartEq) <= 1, 1);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic rand_step(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(39) == 0) AlarmTrigger = ~AlarmTrigger;
            if ($urandom_range(15) == 0) Retry = ~Retry;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(5) == 0) EqCorrect[b] = ~EqCorrect[b];
            Reset = ($urandom_range(599) == 0);
            step(1);
        end
        Reset = 1'b0;
    endtask

    initial begin
        model_reset();
        Reset = 1'b1; AlarmTrigger = 1'b1; Retry = 1'b0; EqCorrect = 3'b000;
        step(3);
        check("rst_start", StartEq, 0);
        check("rst_alarm_on", AlarmOn, 0);
        check("rst_timer", OngoingTimer, 0);

        // Alarm held high through reset: no round may start.
        Reset = 1'b0;
        step(5);
        check("held_no_round", AlarmOn, 0);

        AlarmTrigger = 1'b0; step(2);
        AlarmTrigger = 1'b1; step(1);          // edge N samples the rise
        check("n_still_idle", AlarmOn, 0);
        step(1);                               // N+1: ARM
        check("n1_start", StartEq, 3'b001);
        check("n1_alarm_on", AlarmOn, 1);
        step(1);                               // N+2: WAIT
        check("n2_start", StartEq, 0);
        step(2);

        // Wrong stage's flag is ignored.
        EqCorrect = 3'b100; step(3);
        check("wrong_eq_stage", Stage, 0);
        check("wrong_eq_start", StartEq, 0);
        EqCorrect = 3'b000;

        Retry = 1'b1; step(2);
        check("retry_start", StartEq, 3'b001);
        check("retry_penalty", Penalty, 0);
        Retry = 1'b0; step(2);

        EqCorrect = 3'b001; step(2);           // M, M+1: RELEASE
        check("rel0_start", StartEq, 3'b001);
        step(1);                               // M+2: ARM stage 1
        check("arm1_start", StartEq, 3'b010);
        check("arm1_stage", Stage, 1);
        EqCorrect = 3'b000;
        step(18);
        check("timeout_penalty", Penalty, 1);

        rand_step(600);

        // Penalty saturation: a fresh round with no correct flags at all.
        Reset = 1'b1; AlarmTrigger = 1'b0; Retry = 1'b0; EqCorrect = 3'b000; step(1);
        Reset = 1'b0; step(2);
        AlarmTrigger = 1'b1; step(320);
        check("penalty_sat", Penalty, 15);

        // Reset during WAIT of stage 1 with the alarm still held.
        AlarmTrigger = 1'b0; step(2);
        AlarmTrigger = 1'b1; step(3);
        EqCorrect = 3'b001; step(4);
        EqCorrect = 3'b000; step(2);
        check("pre_rst_stage", Stage, 1);
        Reset = 1'b1; step(1);
        check("mid_rst_start", StartEq, 0);
        check("mid_rst_stage", Stage, 0);
        check("mid_rst_alarm_on", AlarmOn, 0);
        check("mid_rst_penalty", Penalty, 0);
        Reset = 1'b0; step(10);
        check("post_rst_idle", AlarmOn, 0);
        AlarmTrigger = 1'b0; step(2);
        AlarmTrigger = 1'b1; step(2);
        check("restart_start", StartEq, 3'b001);

        rand_step(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
